// File: rtl/serdes_pkg.sv
`default_nettype none
// ============================================================================
// serdes_pkg : widths and helpers shared by the serializer/deserializer pair
// Rev 1.0
// ============================================================================
package serdes_pkg;

  localparam int DEF_NARROW_W = 32;
  localparam int DEF_WIDE_W   = 512;

  function automatic int nseg(input int wide, input int narrow);
    return wide / narrow;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/deserializer_if.sv
`default_nettype none
// ============================================================================
// deserializer_if : narrow-beat input and wide-word pop handshake bundle
// Rev 1.0
// ============================================================================
interface deserializer_if
  import serdes_pkg::*;
#(
  parameter int in_bit_width  = DEF_NARROW_W,
  parameter int out_bit_width = DEF_WIDE_W
);
  logic                     write_data;
  logic [in_bit_width-1:0]  data_in;
  logic                     read_data;
  logic                     data_ready;
  logic [out_bit_width-1:0] data_out;
  logic                     overflow;

  modport master (
    output write_data, data_in, read_data,
    input  data_ready, data_out, overflow
  );

  modport slave (
    input  write_data, data_in, read_data,
    output data_ready, data_out, overflow
  );
endinterface
`default_nettype wire

// File: rtl/serdes_word_fifo.sv
`default_nettype none
// ============================================================================
// serdes_word_fifo : show-ahead word FIFO, pop is honoured before push when full
// Rev 1.0
// ============================================================================
module serdes_word_fifo
  import serdes_pkg::*;
#(
  parameter int width = DEF_WIDE_W,
  parameter int depth = 2
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_push,
  input  wire logic             i_pop,
  input  wire logic [width-1:0] i_din,
  output logic      [width-1:0] o_head,
  output logic                  o_full,
  output logic                  o_empty
);
  localparam int PTR_W = cnt_w(depth);

  logic [width-1:0] r_mem [depth];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_pop;
  logic w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PTR_W+1)'(depth));
  assign o_head  = r_mem[r_rd_ptr];

  // A pop frees the slot the concurrent push needs, so full does not block it.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < depth; k++) begin
        r_mem[k] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
// deserializer : gathers NSEG narrow beats (LS slot first) into one wide word
// Rev 1.0
// ============================================================================
module deserializer
  import serdes_pkg::*;
#(
  parameter int in_bit_width  = DEF_NARROW_W,
  parameter int out_bit_width = DEF_WIDE_W,
  parameter int out_depth     = 2
) (
  input wire logic clk,
  input wire logic reset,
  deserializer_if.slave bus
);
  localparam int NSEG  = nseg(out_bit_width, in_bit_width);
  localparam int SEG_W = cnt_w(NSEG);
  localparam int ASM_W = (NSEG - 1) * in_bit_width;

  if ((out_bit_width % in_bit_width) != 0 || NSEG < 2 ||
      out_depth < 2 || (out_depth & (out_depth - 1)) != 0) begin : g_param_err
    $error("deserializer: illegal width/depth parameters");
  end

  logic [SEG_W-1:0]         r_seg_cnt;
  logic [ASM_W-1:0]         r_asm;
  logic                     r_overflow;

  logic                     w_last;
  logic [out_bit_width-1:0] w_word;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_drop;

  assign w_last = bus.write_data && (r_seg_cnt == SEG_W'(NSEG - 1));
  assign w_word = {bus.data_in, r_asm};
  // Dropped only if the FIFO stays full through this edge (no pop alongside).
  assign w_drop = w_last && w_full && !(bus.read_data && !w_empty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg_cnt  <= '0;
      r_asm      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (bus.write_data) begin
        if (w_last) begin
          r_seg_cnt <= '0;
        end else begin
          r_seg_cnt <= r_seg_cnt + SEG_W'(1);
          for (int k = 0; k < NSEG - 1; k++) begin
            if (r_seg_cnt == SEG_W'(k)) begin
              r_asm[k*in_bit_width +: in_bit_width] <= bus.data_in;
            end
          end
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  serdes_word_fifo #(
    .width (out_bit_width),
    .depth (out_depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_last),
    .i_pop   (bus.read_data),
    .i_din   (w_word),
    .o_head  (bus.data_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.data_ready = !w_empty;
  assign bus.overflow   = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================================
// tb_deserializer : directed bench for the 32->512 deserializer, depth 2
// Rev 1.0
// ============================================================================
module tb_deserializer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  deserializer_if #(.in_bit_width(32), .out_bit_width(512)) bus ();

  deserializer #(
    .in_bit_width  (32),
    .out_bit_width (512),
    .out_depth     (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Word whose slot k holds base+k.
  function automatic logic [511:0] mkword(input int base);
    logic [511:0] w;
    for (int k = 0; k < 16; k++) w[k*32 +: 32] = 32'(base + k);
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.write_data = 1'b0;
    bus.read_data  = 1'b0;
    bus.data_in    = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one continuous word of base..base+15, read_data held at 0.
  task automatic send_word(input int base);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.write_data = 1'b1;
      bus.data_in    = 32'(base + i);
    end
    @(negedge clk);
    bus.write_data = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.data_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready got %b want 0", bus.data_ready);
    end
    vectors++;
    if (bus.overflow !== 1'b0) begin
      miscompares++; $display("FAIL reset_overflow got %b want 0", bus.overflow);
    end
    vectors++;
    if (bus.data_out !== 512'd0) begin
      miscompares++; $display("FAIL reset_data_out got %h want 0", bus.data_out);
    end
  endtask

  task automatic test_single_word();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        vectors++;
        if (bus.data_ready !== 1'b0) begin
          miscompares++; $display("FAIL single_early_ready got %b want 0", bus.data_ready);
        end
      end
      bus.write_data = 1'b1;
      bus.data_in    = 32'(i);
    end
    @(negedge clk);
    bus.write_data = 1'b0;
    vectors++;
    if (bus.data_ready !== 1'b1) begin
      miscompares++; $display("FAIL single_ready got %b want 1", bus.data_ready);
    end
    vectors++;
    if (bus.data_out !== mkword(0)) begin
      miscompares++; $display("FAIL single_word got %h want %h", bus.data_out, mkword(0));
    end
    bus.read_data = 1'b1;
    @(negedge clk);
    bus.read_data = 1'b0;
    vectors++;
    if (bus.data_ready !== 1'b0) begin
      miscompares++; $display("FAIL single_after_pop got %b want 0", bus.data_ready);
    end
  endtask

  task automatic test_back_to_back();
    int w = 0;
    do_reset();
    bus.read_data = 1'b1;
    for (int i = 0; i < 52; i++) begin
      @(negedge clk);
      if (bus.data_ready) begin
        vectors++;
        if (bus.data_out !== mkword(16 * w)) begin
          miscompares++;
          $display("FAIL b2b_word%0d got %h want %h", w, bus.data_out, mkword(16 * w));
        end
        w++;
      end
      if (i < 48) begin
        bus.write_data = 1'b1;
        bus.data_in    = 32'(i);
      end else begin
        bus.write_data = 1'b0;
      end
    end
    bus.read_data = 1'b0;
    vectors++;
    if (w !== 3) begin
      miscompares++; $display("FAIL b2b_ready_cycles got %0d want 3", w);
    end
    vectors++;
    if (bus.overflow !== 1'b0) begin
      miscompares++; $display("FAIL b2b_overflow got %b want 0", bus.overflow);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (i == 47) begin
        vectors++;
        if (bus.overflow !== 1'b0) begin
          miscompares++; $display("FAIL ovf_early got %b want 0", bus.overflow);
        end
      end
      bus.write_data = 1'b1;
      bus.data_in    = 32'(i);
    end
    @(negedge clk);
    bus.write_data = 1'b0;
    vectors++;
    if (bus.overflow !== 1'b1) begin
      miscompares++; $display("FAIL ovf_set got %b want 1", bus.overflow);
    end
    vectors++;
    if (bus.data_out !== mkword(0)) begin
      miscompares++; $display("FAIL ovf_word0 got %h want %h", bus.data_out, mkword(0));
    end
    bus.read_data = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.data_ready !== 1'b1 || bus.data_out !== mkword(16)) begin
      miscompares++;
      $display("FAIL ovf_word1 ready %b got %h want %h", bus.data_ready, bus.data_out, mkword(16));
    end
    @(negedge clk);
    bus.read_data = 1'b0;
    vectors++;
    if (bus.data_ready !== 1'b0) begin
      miscompares++; $display("FAIL ovf_empty got %b want 0", bus.data_ready);
    end
    vectors++;
    if (bus.overflow !== 1'b1) begin
      miscompares++; $display("FAIL ovf_sticky got %b want 1", bus.overflow);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    send_word(0);
    send_word(16);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.write_data = 1'b1;
      bus.data_in    = 32'(32 + i);
      bus.read_data  = (i == 15);
    end
    @(negedge clk);
    bus.write_data = 1'b0;
    vectors++;
    if (bus.overflow !== 1'b0) begin
      miscompares++; $display("FAIL fullpop_overflow got %b want 0", bus.overflow);
    end
    vectors++;
    if (bus.data_out !== mkword(16)) begin
      miscompares++; $display("FAIL fullpop_head got %h want %h", bus.data_out, mkword(16));
    end
    @(negedge clk);
    vectors++;
    if (bus.data_ready !== 1'b1 || bus.data_out !== mkword(32)) begin
      miscompares++;
      $display("FAIL fullpop_next ready %b got %h want %h", bus.data_ready, bus.data_out, mkword(32));
    end
    @(negedge clk);
    bus.read_data = 1'b0;
    vectors++;
    if (bus.data_ready !== 1'b0) begin
      miscompares++; $display("FAIL fullpop_empty got %b want 0", bus.data_ready);
    end
  endtask

  task automatic test_gap_reset();
    do_reset();
    // A full word delivered with 2 idle cycles after each beat.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.write_data = 1'b1;
      bus.data_in    = 32'(200 + i);
      repeat (2) begin
        @(negedge clk);
        bus.write_data = 1'b0;
      end
    end
    vectors++;
    if (bus.data_ready !== 1'b1 || bus.data_out !== mkword(200)) begin
      miscompares++;
      $display("FAIL gap_word ready %b got %h want %h", bus.data_ready, bus.data_out, mkword(200));
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.write_data = 1'b1;
      bus.data_in    = 32'(i);
      repeat (3) begin
        @(negedge clk);
        bus.write_data = 1'b0;
      end
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (bus.data_ready !== 1'b0) begin
      miscompares++; $display("FAIL async_reset_ready got %b want 0", bus.data_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        vectors++;
        if (bus.data_ready !== 1'b0) begin
          miscompares++; $display("FAIL post_reset_early got %b want 0", bus.data_ready);
        end
      end
      bus.write_data = 1'b1;
      bus.data_in    = 32'(100 + i);
    end
    @(negedge clk);
    bus.write_data = 1'b0;
    vectors++;
    if (bus.data_ready !== 1'b1 || bus.data_out !== mkword(100)) begin
      miscompares++;
      $display("FAIL post_reset_word ready %b got %h want %h", bus.data_ready, bus.data_out, mkword(100));
    end
  endtask

  task automatic test_stream();
    logic [511:0] q[$];
    logic [511:0] w;
    logic [511:0] exp;
    int got = 0;
    do_reset();
    bus.read_data = 1'b1;
    for (int n = 0; n < 7; n++) begin
      for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
      if (n < 6) q.push_back(w);
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (bus.data_ready) begin
          exp = (q.size() > 0) ? q.pop_front() : '0;
          vectors++;
          if (bus.data_out !== exp) begin
            miscompares++;
            $display("FAIL stream_word%0d got %h want %h", got, bus.data_out, exp);
          end
          got++;
        end
        bus.write_data = (n < 6);
        bus.data_in    = w[i*32 +: 32];
      end
    end
    bus.write_data = 1'b0;
    bus.read_data  = 1'b0;
    vectors++;
    if (got !== 6 || bus.overflow !== 1'b0) begin
      miscompares++; $display("FAIL stream_count got %0d ovf %b want 6 ovf 0", got, bus.overflow);
    end
  endtask

  initial begin
    bus.write_data = 1'b0;
    bus.read_data  = 1'b0;
    bus.data_in    = '0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_gap_reset();
    test_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
